student_fir_requant: RTL
========================

# student_fir_requant

Output requantizer stage directly downstream of the FIR core. Each FIR result arrives as a 32-bit signed accumulator word with a valid strobe. The block applies a programmable arithmetic right shift with round-half-up, saturates the result to a 16-bit signed audio sample, and buffers it in a small FIFO. The FIFO drains through a valid/ready handshake toward the audio output path, and overflow and saturation events are counted for software debug.

## Interface
Parameters:
- DATA_SIZE_FIR_OUT, 32: width of incoming accumulator word.
- DATA_SIZE, 16: width of output sample.
- FIFO_DEPTH, 8: number of FIFO entries; power of two, minimum 2.
- LEVEL_W, $clog2(FIFO_DEPTH)+1: width of the level output.

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_i  in  1  reset; synchronous and active-high.
- valid_strobe_in  in  1  FIR result valid; may stay high for more than one cycle.
- y_in  in  DATA_SIZE_FIR_OUT  FIR result, two's complement.
- shift_i  in  5  right-shift amount, 0..31; sampled together with y_in.
- clear_i  in  1  clears overflow_o and sat_count_o; one-cycle pulse.
- sample_o  out  DATA_SIZE  FIFO head sample, signed.
- sample_valid_o  out  1  sample_o holds valid data.
- sample_ready_i  in  1  downstream accepts sample_o.
- fifo_level_o  out  LEVEL_W  current FIFO occupancy.
- overflow_o  out  1  sticky flag: a sample was dropped because the FIFO was full.
- sat_count_o  out  16  number of saturated samples; stops at 0xFFFF.

## Operation
- Edge detect: a rising edge of valid_strobe_in (high now, low in the previous cycle) is one event. A held-high strobe yields exactly one event. The previous-value register resets to 0.
- Stage 1, capture: on an event, register y_in and shift_i and set stage-1 valid.
- Stage 2, round:
  - Compute sum = sext33(y) + (shift>0 ? 2^(shift-1) : 0) in 33 bits, so no wrap.
  - Compute r = sum >>> shift, an arithmetic shift.
- Stage 3, saturate and push:
  - If r > 32767, write 32767; if r < -32768, write -32768. Otherwise write r[15:0].
  - On saturation, increment sat_count_o, stopping at 0xFFFF.
- FIFO: circular buffer with read/write pointers one bit wider than the address; full/empty come from comparing the pointer MSBs.
  - sample_o always shows the head entry; its contents are don't-care when empty.
  - sample_valid_o = !empty.
  - A pop occurs when sample_valid_o && sample_ready_i.
- Full at push, no pop that cycle: drop the new sample and set overflow_o. The FIFO contents are unchanged.
- Full at push with a pop in the same cycle: accept the push. Level stays FIFO_DEPTH and overflow_o is not set.
- Empty FIFO: a push makes data valid the following cycle. There is no same-cycle bypass.
- clear_i: zeroes overflow_o and sat_count_o.
  - If a new saturation or overflow happens in the same cycle as clear_i, the event wins: sat_count_o becomes 1, or overflow_o becomes 1.
  - FIFO and pipeline contents are not affected.
- Stages never stall; the pipeline accepts one event per cycle.

## Timing
- Reset values: sample_valid_o=0, fifo_level_o=0, overflow_o=0, sat_count_o=0. The pipeline valid bits, pointers and edge register are all 0.
- Reset applies at a clock edge where rst_i=1. It discards all in-flight pipeline and FIFO data.
- Latency with the strobe first high in cycle 0:
  - capture at the end of cycle 0;
  - round at the end of cycle 1;
  - FIFO write at the end of cycle 2;
  - sample_valid_o=1 and fifo_level_o incremented from cycle 3.
- Pop: fifo_level_o decrements and the next head appears on sample_o in the cycle after the accepting edge.
- Simultaneous push and pop on a non-empty, non-full FIFO: the level is unchanged.
- Throughput: one sample per cycle in and out. This is well above the FIR rate of one result per about 2^ADDR_WIDTH cycles.

## Test plan
- Rounding: shift_i=15 with sample_ready_i=1.
  - y_in=0x00004000 -> sample_o=0x0001 at cycle 3.
  - y_in=0x00003FFF -> 0x0000.
  - y_in=0xFFFFC000 -> 0x0000 (half rounds up).
  - y_in=0xFFFFBFFF -> 0xFFFF.
- Saturation, shift_i=15:
  - y_in=0x3FFFFFFF -> 0x7FFF.
  - y_in=0x80000000 -> 0x8000.
  - sat_count_o=2 after both; one clear_i pulse -> 0.
- Shift 0: y_in=0x00001234 -> 0x1234; y_in=0x00012345 -> 0x7FFF and sat_count_o increments.
- Strobe held high for 5 cycles with y_in=0x00010000 and shift_i=4 -> exactly one sample, 0x1000; fifo_level_o peaks at 1.
- Overflow: sample_ready_i=0, 9 events with values 1..9 and shift_i=0.
  - fifo_level_o=8 and overflow_o=1.
  - Raising ready drains 1..8 in order, then sample_valid_o=0.
- Full with simultaneous pop: FIFO full, pop and push in the same cycle -> level stays 8 and overflow_o stays 0.
- Reset mid-operation: assert rst_i for one cycle with 3 entries buffered and one event in flight -> level 0, valid 0, no sample emerges afterwards.

Source files
------------

// File: rtl/student_fir_requant.sv
// student_fir_requant: requantizes 32-bit FIR accumulator words to 16-bit
// samples. The path is: rising-edge detect on the strobe, capture,
// round-half-up arithmetic shift, then saturate. Results go into a small
// FIFO that drains over valid/ready. Sticky overflow and saturation
// counters are kept for software debug.
module student_fir_requant #(
    parameter int DATA_SIZE_FIR_OUT = 32,
    parameter int DATA_SIZE         = 16,
    parameter int FIFO_DEPTH        = 8,
    parameter int LEVEL_W           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         valid_strobe_in,
    input  logic [DATA_SIZE_FIR_OUT-1:0] y_in,
    input  logic [4:0]                   shift_i,
    input  logic                         clear_i,
    output logic [DATA_SIZE-1:0]         sample_o,
    output logic                         sample_valid_o,
    input  logic                         sample_ready_i,
    output logic [LEVEL_W-1:0]           fifo_level_o,
    output logic                         overflow_o,
    output logic [15:0]                  sat_count_o
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int SW     = DATA_SIZE_FIR_OUT + 1;  // one guard bit so the rounding add never wraps
    localparam int STAGES = 2;

    localparam logic signed [SW-1:0] SAT_MAX = SW'((1 <<< (DATA_SIZE - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    // ------------------------------------------------------------------
    // Edge detect and pipeline valid bits
    // ------------------------------------------------------------------
    logic              strobe_q;
    logic              evt;
    logic [STAGES:1]   vld_pipe;

    assign evt = valid_strobe_in & ~strobe_q;

    // Previous strobe value and the per-stage valid shift register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            strobe_q <= 1'b0;
            vld_pipe <= '0;
        end else begin
            strobe_q <= valid_strobe_in;
            vld_pipe <= {vld_pipe[STAGES-1:1], evt};
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: capture
    // ------------------------------------------------------------------
    logic [DATA_SIZE_FIR_OUT-1:0] y_s1;
    logic [4:0]                   sh_s1;

    // Capture the accumulator word and its shift only on an event.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            y_s1  <= '0;
            sh_s1 <= '0;
        end else if (evt) begin
            y_s1  <= y_in;
            sh_s1 <= shift_i;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round-half-up and arithmetic shift
    // ------------------------------------------------------------------
    logic        [SW-1:0] rnd_s1;
    logic signed [SW-1:0] sum_s1;
    logic signed [SW-1:0] shr_s1;
    logic signed [SW-1:0] r_s2;

    // Add half an LSB of the result before shifting; a zero shift adds nothing.
    always_comb begin
        rnd_s1 = '0;
        if (sh_s1 != 5'd0)
            rnd_s1 = SW'(1) << (sh_s1 - 5'd1);
        sum_s1 = $signed({y_s1[DATA_SIZE_FIR_OUT-1], y_s1}) + $signed(rnd_s1);
        shr_s1 = sum_s1 >>> sh_s1;
    end

    // Register the rounded, shifted value.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_s2 <= '0;
        else if (vld_pipe[1])
            r_s2 <= shr_s1;
    end

    // ------------------------------------------------------------------
    // Stage 3: saturate and push
    // ------------------------------------------------------------------
    logic                 push;
    logic                 sat_hi;
    logic                 sat_lo;
    logic                 sat_ev;
    logic [DATA_SIZE-1:0] sat_data;

    // Clamp to the signed output range.
    always_comb begin
        push     = vld_pipe[2];
        sat_hi   = (r_s2 > SAT_MAX);
        sat_lo   = (r_s2 < SAT_MIN);
        sat_ev   = push & (sat_hi | sat_lo);
        sat_data = r_s2[DATA_SIZE-1:0];
        if (sat_hi)
            sat_data = SAT_MAX[DATA_SIZE-1:0];
        else if (sat_lo)
            sat_data = SAT_MIN[DATA_SIZE-1:0];
    end

    // ------------------------------------------------------------------
    // FIFO: pointers carry an extra wrap bit to separate full from empty
    // ------------------------------------------------------------------
    logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 empty;
    logic                 full;
    logic                 pop;
    logic                 wr_en;
    logic                 ovf_set;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // only dropped when nothing drains.
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop     = ~empty & sample_ready_i;
        wr_en   = push & (~full | pop);
        ovf_set = push & full & ~pop;
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= sat_data;
    end

    // Read and write pointer advance.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign sample_o       = mem[rd_ptr[AW-1:0]];
    assign sample_valid_o = ~empty;
    assign fifo_level_o   = LEVEL_W'(wr_ptr - rd_ptr);

    // ------------------------------------------------------------------
    // Debug counters: a new event in the clear cycle takes priority
    // ------------------------------------------------------------------

    // Sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            overflow_o <= 1'b0;
        else if (ovf_set)
            overflow_o <= 1'b1;
        else if (clear_i)
            overflow_o <= 1'b0;
    end

    // Saturation counter, holds at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            sat_count_o <= '0;
        else if (clear_i)
            sat_count_o <= sat_ev ? 16'd1 : 16'd0;
        else if (sat_ev && (sat_count_o != 16'hFFFF))
            sat_count_o <= sat_count_o + 16'd1;
    end

endmodule
